// File: rtl/key_pkg.sv
// key_pkg: shared types and constants for the key conditioning block.
//   key_state_t : per-channel debounce FSM states.
//   KEY_UP/KEY_DOWN : bit positions of the two buttons in key_in/key_pulse/key_level.
package key_pkg;

   typedef enum logic [1:0] {
      RELEASED   = 2'd0,
      PRESS_DB   = 2'd1,
      HELD       = 2'd2,
      RELEASE_DB = 2'd3
   } key_state_t;

   localparam int KEY_UP   = 0;
   localparam int KEY_DOWN = 1;

endpackage

// File: rtl/key_pulse_gen_if.sv
// key_pulse_gen_if: button-side bundle of the key conditioning block.
//   key_in    : raw buttons, 1 = pressed, asynchronous to clk ([0] UP, [1] DOWN)
//   key_pulse : one-cycle press strobes toward the counter
//   key_level : debounced stable level per key
// Modports: master = button/consumer side, slave = key_pulse_gen.
interface key_pulse_gen_if;

   logic [1:0] key_in;
   logic [1:0] key_pulse;
   logic [1:0] key_level;

   modport master (
      output key_in,
      input  key_pulse,
      input  key_level
   );

   modport slave (
      input  key_in,
      output key_pulse,
      output key_level
   );

endinterface

// File: rtl/key_db_channel.sv
// key_db_channel: one button channel -- 2-flop synchroniser, debounce FSM,
// single-cycle press pulse and debounced level.
// Optional auto-repeat while held is compiled in with `define KEY_AUTOREPEAT_EN.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   key_raw   : raw button (async)
//   key_pulse : registered one-cycle strobe per accepted press (plus repeats)
//   key_level : registered debounced level
module key_db_channel
   import key_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 2_000_000,
   parameter int CNT_W           = 21,
   parameter int REPEAT_DELAY    = 50_000_000,
   parameter int REPEAT_PERIOD   = 10_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic key_raw,
   output logic key_pulse,
   output logic key_level
);

   // Reject configurations where the debounce counter could not reach its terminal value.
   if (DEBOUNCE_CYCLES < 2 || CNT_W < 1 || CNT_W > 30 || (2 ** CNT_W) <= DEBOUNCE_CYCLES
       || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
      $error("key_db_channel: invalid parameter set");
   end

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q;
   logic             s_q;
   key_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pulse_q, pulse_d;
   logic             level_q, level_d;
   logic             db_done;
   logic             rpt_fire;

   assign db_done = (cnt_q == CNT_LAST);

   // State register: synchroniser, FSM, counter and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         s_q     <= 1'b0;
         state_q <= RELEASED;
         cnt_q   <= '0;
         pulse_q <= 1'b0;
         level_q <= 1'b0;
      end else begin
         sync1_q <= key_raw;
         s_q     <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
         level_q <= level_d;
      end
   end

   // Next state. The counter restarts on every state change, so it never wraps.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         RELEASED: begin
            if (s_q) begin
               state_d = PRESS_DB;
               cnt_d   = CNT_W'(1);
            end else begin
               cnt_d   = '0;
            end
         end
         PRESS_DB: begin
            if (!s_q) begin
               state_d = RELEASED;
               cnt_d   = '0;
            end else if (db_done) begin
               state_d = HELD;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         HELD: begin
            if (!s_q) begin
               state_d = RELEASE_DB;
               cnt_d   = CNT_W'(1);
            end else begin
               cnt_d   = '0;
            end
         end
         RELEASE_DB: begin
            if (s_q) begin
               state_d = HELD;
               cnt_d   = '0;
            end else if (db_done) begin
               state_d = RELEASED;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = RELEASED;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs: pulse only on the accepting transition into HELD; level follows accepted edges.
   always_comb begin
      pulse_d = rpt_fire;
      level_d = level_q;
      case (state_q)
         PRESS_DB: begin
            if (s_q && db_done) begin
               pulse_d = 1'b1;
               level_d = 1'b1;
            end
         end
         RELEASE_DB: begin
            if (!s_q && db_done) begin
               level_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

`ifdef KEY_AUTOREPEAT_EN
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RPT_W   = $clog2(RPT_MAX + 1);

   logic [RPT_W-1:0] rpt_q, rpt_d;
   logic             rpt_phase_q, rpt_phase_d;  // 0: waiting initial delay, 1: periodic

   // Repeat counter runs only while HELD with the key still down; it is frozen in
   // RELEASE_DB so a release glitch does not restart the repeat timing.
   always_comb begin
      rpt_d       = rpt_q;
      rpt_phase_d = rpt_phase_q;
      rpt_fire    = 1'b0;
      case (state_q)
         HELD: begin
            if (s_q) begin
               if (rpt_q == (rpt_phase_q ? RPT_W'(REPEAT_PERIOD - 1) : RPT_W'(REPEAT_DELAY - 1))) begin
                  rpt_fire    = 1'b1;
                  rpt_d       = '0;
                  rpt_phase_d = 1'b1;
               end else begin
                  rpt_d       = rpt_q + RPT_W'(1);
               end
            end
         end
         RELEASE_DB: begin
            if (!s_q && db_done) begin
               rpt_d       = '0;
               rpt_phase_d = 1'b0;
            end
         end
         default: begin
            rpt_d       = '0;
            rpt_phase_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rpt_q       <= '0;
         rpt_phase_q <= 1'b0;
      end else begin
         rpt_q       <= rpt_d;
         rpt_phase_q <= rpt_phase_d;
      end
   end
`else
   assign rpt_fire = 1'b0;
`endif

   assign key_pulse = pulse_q;
   assign key_level = level_q;

endmodule

// File: rtl/key_pulse_gen.sv
// key_pulse_gen: conditions the UP/DOWN push buttons into clean key strobes.
// Each bit is synchronised, debounced and turned into one pulse per press.
// Optional auto-repeat while held: `define KEY_AUTOREPEAT_EN.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : key_pulse_gen_if.slave (key_in in, key_pulse/key_level out)
module key_pulse_gen
   import key_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 2_000_000,
   parameter int CNT_W           = 21,
   parameter int REPEAT_DELAY    = 50_000_000,
   parameter int REPEAT_PERIOD   = 10_000_000
) (
   input  logic             clk,
   input  logic             rst,
   key_pulse_gen_if.slave   bus
);

   localparam int NUM_KEYS = KEY_DOWN - KEY_UP + 1;

   logic [NUM_KEYS-1:0] pulse_w;
   logic [NUM_KEYS-1:0] level_w;

   // Channels are fully independent; simultaneous presses pass through as 2'b11.
   for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_ch
      key_db_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .key_raw   (bus.key_in[gi]),
         .key_pulse (pulse_w[gi]),
         .key_level (level_w[gi])
      );
   end

   assign bus.key_pulse = pulse_w;
   assign bus.key_level = level_w;

endmodule

// File: tb/tb_key_pulse_gen.sv
module tb_key_pulse_gen;

   typedef struct {
      int         cyc;
      logic [1:0] pulse;
      logic [1:0] level;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   n_checks;
   int   n_fail;
   exp_t sb_q[$];

   key_pulse_gen_if bus ();

   key_pulse_gen #(
      .DEBOUNCE_CYCLES (4),
      .CNT_W           (3),
      .REPEAT_DELAY    (10),
      .REPEAT_PERIOD   (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s obs=%0h exp=%0h (cyc=%0d)", tag, obs, exp_v, cyc);
      end
   endtask

   // Scoreboard consumer: every non-zero pulse must match the next expected entry.
   always @(negedge clk) begin
      if (!rst && bus.key_pulse != 2'b00) begin
         $display("pulse cyc=%0d key_pulse=%b key_level=%b", cyc, bus.key_pulse, bus.key_level);
         if (sb_q.size() == 0) begin
            chk("spurious_pulse", 32'(bus.key_pulse), 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("pulse_val", 32'(bus.key_pulse), 32'(e.pulse));
            chk("pulse_cyc", cyc, e.cyc);
            chk("pulse_level", 32'(bus.key_level), 32'(e.level));
         end
      end
   end

   task automatic push_exp(input int c, input logic [1:0] p, input logic [1:0] l);
      exp_t e;
      e.cyc = c;
      e.pulse = p;
      e.level = l;
      sb_q.push_back(e);
   endtask

   // Drive key_in just after a rising edge; returns the edge count at drive time.
   task automatic drive(input logic [1:0] v, output int n);
      @(posedge clk);
      #1;
      bus.key_in = v;
      n = cyc;
   endtask

   // Advance to the falling edge at which cyc == c (bounded: cyc only grows).
   task automatic wait_cyc(input int c);
      do @(negedge clk); while (cyc < c);
   endtask

   int n, m, r;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1;
      bus.key_in = 2'b00;
      #3;
      chk("reset_pulse", 32'(bus.key_pulse), 32'd0);
      chk("reset_level", 32'(bus.key_level), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

`ifdef KEY_AUTOREPEAT_EN
      // Auto-repeat: first pulse, one 10 cycles later, then every 3 cycles.
      drive(2'b01, n);
      push_exp(n + 6,  2'b01, 2'b01);
      push_exp(n + 16, 2'b01, 2'b01);
      push_exp(n + 19, 2'b01, 2'b01);
      push_exp(n + 22, 2'b01, 2'b01);
      push_exp(n + 25, 2'b01, 2'b01);
      push_exp(n + 28, 2'b01, 2'b01);
      wait_cyc(n + 26);
      drive(2'b00, r);
      wait_cyc(n + 45);
      chk("rpt_level_fall", 32'(bus.key_level), 32'd0);
      chk("rpt_drain", sb_q.size(), 32'd0);
`else
      // Press on UP, then asynchronous reset mid-cycle while level is high.
      drive(2'b01, n);
      push_exp(n + 6, 2'b01, 2'b01);
      wait_cyc(n + 8);
      chk("press_level", 32'(bus.key_level), 32'd1);
      chk("press_drain", sb_q.size(), 32'd0);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_pulse", 32'(bus.key_pulse), 32'd0);
      chk("async_rst_level", 32'(bus.key_level), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      m = cyc;
      push_exp(m + 6, 2'b01, 2'b01);
      wait_cyc(m + 8);
      chk("repress_level", 32'(bus.key_level), 32'd1);
      drive(2'b00, r);
      wait_cyc(r + 5);
      chk("release_level_hold", 32'(bus.key_level), 32'd1);
      wait_cyc(r + 6);
      chk("release_level_fall", 32'(bus.key_level), 32'd0);

      // Bounce on DOWN: 1,0,1,0 every 2 cycles then 0 -> nothing accepted.
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
         bus.key_in = (k % 2 == 0) ? 2'b10 : 2'b00;
         repeat (2) begin
            @(negedge clk);
            chk("bounce_level", 32'(bus.key_level), 32'd0);
            @(posedge clk);
            #1;
         end
      end
      repeat (8) begin
         @(negedge clk);
         chk("bounce_settle", 32'(bus.key_level), 32'd0);
      end

      // Long hold: exactly one pulse, level falls 6 edges after release.
      drive(2'b01, n);
      push_exp(n + 6, 2'b01, 2'b01);
      wait_cyc(n + 40);
      chk("hold_level", 32'(bus.key_level), 32'd1);
      drive(2'b00, r);
      wait_cyc(r + 5);
      chk("hold_rel_level_hold", 32'(bus.key_level), 32'd1);
      wait_cyc(r + 6);
      chk("hold_rel_level_fall", 32'(bus.key_level), 32'd0);
      wait_cyc(r + 10);

      // Simultaneous press on both keys.
      drive(2'b11, n);
      push_exp(n + 6, 2'b11, 2'b11);
      wait_cyc(n + 10);
      chk("both_level", 32'(bus.key_level), 32'd3);
      drive(2'b00, r);
      wait_cyc(r + 6);
      chk("both_rel_level", 32'(bus.key_level), 32'd0);
      wait_cyc(r + 10);

      // Reset mid-hold on DOWN: new pulse after re-debounce.
      drive(2'b10, n);
      push_exp(n + 6, 2'b10, 2'b10);
      do begin
         @(posedge clk);
         #1;
      end while (cyc < n + 8);
      rst = 1'b1;
      #1;
      chk("midhold_rst_pulse", 32'(bus.key_pulse), 32'd0);
      chk("midhold_rst_level", 32'(bus.key_level), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      m = cyc;
      push_exp(m + 6, 2'b10, 2'b10);
      wait_cyc(m + 8);
      chk("midhold_relevel", 32'(bus.key_level), 32'd2);
      drive(2'b00, r);
      wait_cyc(r + 6);
      chk("midhold_rel_level", 32'(bus.key_level), 32'd0);
      wait_cyc(r + 5 + 4);
      chk("sb_drain", sb_q.size(), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
